// File: rtl/systolic_scheduler.sv
// ---------------------------------------------------------------------------
// systolic_scheduler
//
// Round-robin scheduler that time-shares one SystolicArray instance between
// NUM_REQ matrix-op requesters (the Kalman predict/update stage FSMs). One
// requester is granted at a time. While the array runs, the scheduler drives
// load_en and the column-group enables. It qualifies the array's sticky
// cal_finish flag with its own run counter and answers each job with a
// one-cycle done pulse. Illegal column codes and run timeouts raise err
// together with done, so the requester is never left waiting.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   req_i            per-requester request level
//   req_cols_i       per-requester column code, bits [2i+1:2i]
//                    (0 = col 1, 1 = cols 1-6, 2 = cols 1-12, 3 = illegal)
//   gnt_o            one-hot grant (registered)
//   gnt_idx_o        index of the granted requester, 0 when idle (registered)
//   sa_load_en_o     array load_en
//   sa_enb_1_o       array column-1 enable
//   sa_enb_2_6_o     array columns 2-6 enable
//   sa_enb_7_12_o    array columns 7-12 enable
//   sa_cal_finish_i  array completion flag (sticky once set)
//   done_o           one-cycle completion pulse to the granted requester
//   err_o            one-cycle pulse on illegal code or timeout
//   busy_o           high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module systolic_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int N       = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [2*NUM_REQ-1:0]       req_cols_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       sa_load_en_o,
    output logic                       sa_enb_1_o,
    output logic                       sa_enb_2_6_o,
    output logic                       sa_enb_7_12_o,
    input  logic                       sa_cal_finish_i,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       err_o,
    output logic                       busy_o
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int MIN_RUN = 2 * N - 1;

    localparam logic [1:0] CODE_COL1   = 2'd0;
    localparam logic [1:0] CODE_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t               state_q,   state_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [1:0]           code_q,    code_d;
    logic [IDX_W-1:0]     rrPtr_q,   rrPtr_d;
    logic [CNT_W-1:0]     runCnt_q,  runCnt_d;
    logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
    logic [IDX_W-1:0]     gntIdx_q,  gntIdx_d;
    logic                 loadEn_q,  loadEn_d;
    logic                 enb1_q,    enb1_d;
    logic                 enb26_q,   enb26_d;
    logic                 enb712_q,  enb712_d;
    logic [NUM_REQ-1:0]   done_q,    done_d;
    logic                 err_q,     err_d;
    logic                 busy_q,    busy_d;

    logic                 pickValid;
    logic [IDX_W-1:0]     pickIdx;
    logic [1:0]           pickCode;
    logic [NUM_REQ-1:0]   idxOneHot;
    logic [NUM_REQ-1:0]   pickOneHot;
    logic [IDX_W-1:0]     idxNext;

    function automatic logic [NUM_REQ-1:0] oneHot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: scan offsets from the highest down so that the
    // requester closest to rrPtr_q (lowest offset) is the last one written
    // and therefore wins.
    always_comb begin
        int slot;
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            slot = int'(rrPtr_q) + k;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (req_i[IDX_W'(slot)]) begin
                pickValid = 1'b1;
                pickIdx   = IDX_W'(slot);
            end
        end
    end

    // Column code of the candidate, and helper decodes shared by the FSM.
    always_comb begin
        pickCode   = req_cols_i[{pickIdx, 1'b0} +: 2];
        pickOneHot = oneHot(pickIdx);
        idxOneHot  = oneHot(idx_q);
        idxNext    = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + IDX_W'(1);
    end

    // Next-state and next-output logic. Every output is computed here for
    // the state being entered, so the registered outputs line up with the
    // registered state without an extra cycle of lag. The enables only
    // follow the latched code while the array is actually running.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        code_d   = code_q;
        rrPtr_d  = rrPtr_q;
        runCnt_d = runCnt_q;
        gnt_d    = '0;
        gntIdx_d = '0;
        loadEn_d = 1'b0;
        enb1_d   = 1'b0;
        enb26_d  = 1'b0;
        enb712_d = 1'b0;
        done_d   = '0;
        err_d    = 1'b0;
        busy_d   = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (pickValid) begin
                    idx_d    = pickIdx;
                    code_d   = pickCode;
                    gnt_d    = pickOneHot;
                    gntIdx_d = pickIdx;
                    if (pickCode == CODE_ILLEGAL) begin
                        // Unblock the requester right away and flag the error.
                        state_d = ERR;
                        err_d   = 1'b1;
                        done_d  = pickOneHot;
                    end else begin
                        state_d = GRANT;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end

            GRANT: begin
                // One settle cycle with load_en low clears the array counter
                // before the run starts.
                state_d  = RUN;
                runCnt_d = '0;
                gnt_d    = idxOneHot;
                gntIdx_d = idx_q;
                loadEn_d = 1'b1;
                enb1_d   = 1'b1;
                enb26_d  = (code_q != CODE_COL1);
                enb712_d = (code_q == 2'd2);
            end

            RUN: begin
                if (runCnt_q != CNT_W'(TIMEOUT)) begin
                    runCnt_d = runCnt_q + CNT_W'(1);
                end
                gnt_d    = idxOneHot;
                gntIdx_d = idx_q;
                if (!req_i[idx_q]) begin
                    // Requester withdrew: silent abort, nothing reported.
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gntIdx_d = '0;
                    busy_d   = 1'b0;
                end else if (sa_cal_finish_i && (runCnt_q >= CNT_W'(MIN_RUN))) begin
                    // cal_finish is sticky from the previous job, so it only
                    // counts once the array has had a full pass to finish.
                    state_d = DONE;
                    done_d  = idxOneHot;
                end else if (runCnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    done_d  = idxOneHot;
                end else begin
                    loadEn_d = 1'b1;
                    enb1_d   = 1'b1;
                    enb26_d  = (code_q != CODE_COL1);
                    enb712_d = (code_q == 2'd2);
                end
            end

            DONE, ERR: begin
                state_d = IDLE;
                rrPtr_d = idxNext;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset in the
    // middle of a job drops everything without any done or err pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            code_q   <= '0;
            rrPtr_q  <= '0;
            runCnt_q <= '0;
            gnt_q    <= '0;
            gntIdx_q <= '0;
            loadEn_q <= 1'b0;
            enb1_q   <= 1'b0;
            enb26_q  <= 1'b0;
            enb712_q <= 1'b0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            rrPtr_q  <= rrPtr_d;
            runCnt_q <= runCnt_d;
            gnt_q    <= gnt_d;
            gntIdx_q <= gntIdx_d;
            loadEn_q <= loadEn_d;
            enb1_q   <= enb1_d;
            enb26_q  <= enb26_d;
            enb712_q <= enb712_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign gnt_idx_o     = gntIdx_q;
    assign sa_load_en_o  = loadEn_q;
    assign sa_enb_1_o    = enb1_q;
    assign sa_enb_2_6_o  = enb26_q;
    assign sa_enb_7_12_o = enb712_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_systolic_scheduler.sv
// ---------------------------------------------------------------------------
// tb_systolic_scheduler
//
// Directed bench for systolic_scheduler (NUM_REQ=4, N=12, TIMEOUT=64).
// Inputs are driven and outputs sampled on the falling clock edge. Cycle
// counts are taken from the negedge on which req is raised: the design
// samples it on the following posedge, so the grant shows up at count 1,
// the first RUN cycle at count 2 and the done pulse of a normal job at
// count 26.
// ---------------------------------------------------------------------------
module tb_systolic_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] reqCols;
    logic       cal;
    logic [3:0] gnt;
    logic [1:0] gntIdx;
    logic       load;
    logic       enb1;
    logic       enb26;
    logic       enb712;
    logic [3:0] done;
    logic       err;
    logic       busy;

    int checks;
    int errors;

    systolic_scheduler #(
        .NUM_REQ (4),
        .N       (12),
        .TIMEOUT (64)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .req_cols_i      (reqCols),
        .gnt_o           (gnt),
        .gnt_idx_o       (gntIdx),
        .sa_load_en_o    (load),
        .sa_enb_1_o      (enb1),
        .sa_enb_2_6_o    (enb26),
        .sa_enb_7_12_o   (enb712),
        .sa_cal_finish_i (cal),
        .done_o          (done),
        .err_o           (err),
        .busy_o          (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst     = 1'b1;
        req     = 4'b0000;
        cal     = 1'b0;
        reqCols = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset must win over pending requests and clear every output.
    task automatic test_reset();
        rst     = 1'b1;
        req     = 4'b1111;
        cal     = 1'b1;
        reqCols = 8'hAA;
        tick();
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt got %b want 0000", gnt); end
        checks++; if (gntIdx !== 2'd0) begin errors++; $display("[TB] FAIL reset_gnt_idx got %0d want 0", gntIdx); end
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load got %b want 0", load); end
        checks++; if ({enb1, enb26, enb712} !== 3'b000) begin errors++; $display("[TB] FAIL reset_enb got %b want 000", {enb1, enb26, enb712}); end
        checks++; if (done !== 4'b0000) begin errors++; $display("[TB] FAIL reset_done got %b want 0000", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        req = 4'b0000;
        cal = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    // Single full-width job with cal_finish already high.
    task automatic test_single_job();
        int         loadCnt;
        int         doneAt;
        logic [3:0] doneVal;
        bit         badEnb;
        bit         sawErr;
        loadCnt = 0;
        doneAt  = 0;
        doneVal = '0;
        badEnb  = 0;
        sawErr  = 0;
        reqCols = 8'hAA;
        cal     = 1'b1;
        req     = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt got %b want 0001", gnt); end
        checks++; if (gntIdx !== 2'd0) begin errors++; $display("[TB] FAIL single_gnt_idx got %0d want 0", gntIdx); end
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL single_grant_load got %b want 0", load); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", busy); end
        for (int c = 2; c <= 40 && doneAt == 0; c++) begin
            tick();
            if (load) begin
                loadCnt++;
                if ({enb1, enb26, enb712} !== 3'b111) badEnb = 1;
            end else if ({enb1, enb26, enb712} !== 3'b000) begin
                badEnb = 1;
            end
            if (err) sawErr = 1;
            if (done !== 4'b0000) begin
                doneAt  = c;
                doneVal = done;
            end
        end
        req = 4'b0000;
        checks++; if (doneAt !== 26) begin errors++; $display("[TB] FAIL single_done_time got %0d want 26", doneAt); end
        checks++; if (doneVal !== 4'b0001) begin errors++; $display("[TB] FAIL single_done_val got %b want 0001", doneVal); end
        checks++; if (loadCnt !== 24) begin errors++; $display("[TB] FAIL single_load_cycles got %0d want 24", loadCnt); end
        checks++; if (badEnb !== 1'b0) begin errors++; $display("[TB] FAIL single_enables got bad=%b want bad=0", badEnb); end
        checks++; if (sawErr !== 1'b0) begin errors++; $display("[TB] FAIL single_err got %b want 0", sawErr); end
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL single_post_gnt got %b want 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_post_busy got %b want 0", busy); end
        checks++; if (done !== 4'b0000) begin errors++; $display("[TB] FAIL single_post_done got %b want 0000", done); end
    endtask

    // All four requesting: grants must rotate 0,1,2,3,0.
    task automatic test_round_robin();
        int         nDone;
        int         expIdx;
        logic [3:0] expOh;
        bit         multi;
        doReset();
        nDone   = 0;
        expIdx  = 0;
        multi   = 0;
        reqCols = 8'b10_01_00_10;
        cal     = 1'b1;
        req     = 4'b1111;
        for (int c = 1; c <= 300 && nDone < 5; c++) begin
            tick();
            if ($countones(gnt) > 1) multi = 1;
            if (done !== 4'b0000) begin
                expOh = 4'b0001 << expIdx;
                checks++; if (done !== expOh) begin errors++; $display("[TB] FAIL rr_done_%0d got %b want %b", nDone, done, expOh); end
                checks++; if (gntIdx !== 2'(expIdx)) begin errors++; $display("[TB] FAIL rr_idx_%0d got %0d want %0d", nDone, gntIdx, expIdx); end
                expIdx = (expIdx + 1) % 4;
                nDone++;
            end
        end
        req = 4'b0000;
        checks++; if (nDone !== 5) begin errors++; $display("[TB] FAIL rr_done_count got %0d want 5", nDone); end
        checks++; if (multi !== 1'b0) begin errors++; $display("[TB] FAIL rr_onehot got multi=%b want 0", multi); end
        tick();
        tick();
    endtask

    // Requester 2 with code 3 errors out at once; requester 3 goes next.
    task automatic test_illegal_code();
        doReset();
        reqCols = 8'b00_11_00_00;
        cal     = 1'b1;
        req     = 4'b1100;
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL ill_err got %b want 1", err); end
        checks++; if (done !== 4'b0100) begin errors++; $display("[TB] FAIL ill_done got %b want 0100", done); end
        checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL ill_gnt got %b want 0100", gnt); end
        checks++; if (gntIdx !== 2'd2) begin errors++; $display("[TB] FAIL ill_gnt_idx got %0d want 2", gntIdx); end
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL ill_load got %b want 0", load); end
        req = 4'b1000;
        tick();
        checks++; if ({err, done, load} !== 6'b0) begin errors++; $display("[TB] FAIL ill_idle got err/done/load %b want 000000", {err, done, load}); end
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL ill_next_gnt got %b want 1000", gnt); end
        checks++; if (gntIdx !== 2'd3) begin errors++; $display("[TB] FAIL ill_next_idx got %0d want 3", gntIdx); end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    // cal_finish never arrives: 64 RUN cycles, then err with done.
    task automatic test_timeout();
        int         loadCnt;
        int         doneAt;
        int         errAt;
        logic [3:0] doneVal;
        doReset();
        loadCnt = 0;
        doneAt  = 0;
        errAt   = 0;
        doneVal = '0;
        reqCols = 8'h00;
        cal     = 1'b0;
        req     = 4'b0001;
        for (int c = 1; c <= 100 && errAt == 0; c++) begin
            tick();
            if (load) loadCnt++;
            if (done !== 4'b0000 && doneAt == 0) doneAt = c;
            if (err) begin
                errAt   = c;
                doneVal = done;
            end
        end
        req = 4'b0000;
        checks++; if (errAt !== 66) begin errors++; $display("[TB] FAIL to_err_time got %0d want 66", errAt); end
        checks++; if (doneAt !== 66) begin errors++; $display("[TB] FAIL to_done_time got %0d want 66", doneAt); end
        checks++; if (doneVal !== 4'b0001) begin errors++; $display("[TB] FAIL to_done_val got %b want 0001", doneVal); end
        checks++; if (loadCnt !== 64) begin errors++; $display("[TB] FAIL to_run_cycles got %0d want 64", loadCnt); end
        tick();
        checks++; if ({busy, err, gnt} !== 6'b0) begin errors++; $display("[TB] FAIL to_idle got busy/err/gnt %b want 000000", {busy, err, gnt}); end
    endtask

    // Withdrawal mid-run, then reset mid-run clearing the rr pointer.
    task automatic test_abort_and_reset();
        bit stray;
        int doneAt;
        doReset();
        stray   = 0;
        doneAt  = 0;
        cal     = 1'b1;
        reqCols = 8'hAA;
        req     = 4'b0010;
        for (int c = 1; c <= 12; c++) tick();
        checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL abort_running got %b want 1", load); end
        req = 4'b0000;
        tick();
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL abort_load got %b want 0", load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL abort_gnt got %b want 0000", gnt); end
        if (done !== 4'b0000 || err) stray = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done !== 4'b0000 || err) stray = 1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL abort_stray got %b want 0", stray); end
        // Complete a job on requester 0 so the rr pointer moves to 1.
        req = 4'b0001;
        for (int c = 1; c <= 40 && doneAt == 0; c++) begin
            tick();
            if (done !== 4'b0000) doneAt = c;
        end
        req = 4'b0000;
        checks++; if (doneAt !== 26) begin errors++; $display("[TB] FAIL abort_job0_done got %0d want 26", doneAt); end
        tick();
        // Start requester 0 again and reset it in the middle of RUN.
        req = 4'b0001;
        for (int c = 1; c <= 5; c++) tick();
        rst = 1'b1;
        tick();
        checks++; if ({gnt, gntIdx, load, enb1, enb26, enb712, done, err, busy} !== 16'b0) begin
            errors++; $display("[TB] FAIL rst_run_outputs got %b want all 0", {gnt, gntIdx, load, enb1, enb26, enb712, done, err, busy});
        end
        rst = 1'b0;
        req = 4'b0011;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rst_rr_ptr got %b want 0001", gnt); end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    // Code 1 job: cols 1-6 only, and an early cal_finish blip is ignored.
    task automatic test_code1_early_finish();
        int         loadCnt;
        int         doneAt;
        logic [3:0] doneVal;
        bit         badEnb;
        doReset();
        loadCnt = 0;
        doneAt  = 0;
        doneVal = '0;
        badEnb  = 0;
        reqCols = 8'h01;
        cal     = 1'b0;
        req     = 4'b0001;
        for (int c = 1; c <= 40 && doneAt == 0; c++) begin
            tick();
            if (load) begin
                loadCnt++;
                if ({enb1, enb26, enb712} !== 3'b110) badEnb = 1;
            end
            if (done !== 4'b0000) begin
                doneAt  = c;
                doneVal = done;
            end
            // c==7 is run_cnt 5; from c==17 (run_cnt 15) the flag stays high.
            cal = (c == 7) || (c >= 17);
        end
        req = 4'b0000;
        cal = 1'b0;
        checks++; if (doneAt !== 26) begin errors++; $display("[TB] FAIL c1_done_time got %0d want 26", doneAt); end
        checks++; if (doneVal !== 4'b0001) begin errors++; $display("[TB] FAIL c1_done_val got %b want 0001", doneVal); end
        checks++; if (loadCnt !== 24) begin errors++; $display("[TB] FAIL c1_load_cycles got %0d want 24", loadCnt); end
        checks++; if (badEnb !== 1'b0) begin errors++; $display("[TB] FAIL c1_enables got bad=%b want bad=0", badEnb); end
        tick();
        tick();
    endtask

    // Scenario sequence.
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        req     = 4'b0000;
        reqCols = 8'h00;
        cal     = 1'b0;
        $display("[TB] start");
        test_reset();
        test_single_job();
        test_round_robin();
        test_illegal_code();
        test_timeout();
        test_abort_and_reset();
        test_code1_early_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
